// File: rtl/maze_video_source_if.sv
// ============================================================================
// Module   : maze_video_source_if
// Brief    : Frame-memory read port and video output bus of maze_video_source.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface maze_video_source_if;
   logic        mem_rd;
   logic [19:0] mem_addr;
   logic [7:0]  mem_data;
   logic        video_frame_valid;
   logic        video_line_valid;
   logic        video_data_valid;
   logic [7:0]  video_data_out;
   logic [19:0] video_address;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_data,
      output video_frame_valid,
      output video_line_valid,
      output video_data_valid,
      output video_data_out,
      output video_address
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_data,
      input  video_frame_valid,
      input  video_line_valid,
      input  video_data_valid,
      input  video_data_out,
      input  video_address
   );
endinterface

`default_nettype wire

// File: rtl/maze_video_source.sv
// ============================================================================
// Module   : maze_video_source
// Brief    : Raster video timing generator with frame-memory or synthetic pixels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maze_video_source #(
   parameter int H_ACTIVE = 702,
   parameter int V_ACTIVE = 288,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 64,
   parameter int FV_LEAD  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          mode,
   output logic [9:0]          frame_count,
   output logic                busy,
   maze_video_source_if.master vid
);

   localparam int M1      = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
   localparam int M2      = (V_BLANK > FV_LEAD) ? V_BLANK : FV_LEAD;
   localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int VW      = $clog2(V_ACTIVE + 1);

   localparam logic [CW-1:0] LEAD_LAST = CW'(FV_LEAD - 1);
   localparam logic [CW-1:0] H_LAST    = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VB_LAST   = CW'(V_BLANK - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEAD   = 3'd1,
      ST_LINE   = 3'd2,
      ST_HBLANK = 3'd3,
      ST_VBLANK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [VW-1:0] v_q, v_d;
   logic [1:0]    mode_q, mode_d;
   logic [19:0]   next_addr_q, next_addr_d;
   logic [19:0]   vaddr_q, vaddr_d;
   logic [9:0]    frame_count_q, frame_count_d;
   logic          fv_q, fv_d;
   logic          lv_q, lv_d;
   logic          dv_q, dv_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          mem_rd_q, mem_rd_d;
   logic [19:0]   mem_addr_q, mem_addr_d;

   logic          start_frame;
   logic          in_line;
   logic          next_is_line;
   logic [7:0]    h8;
   logic [7:0]    v8;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      v_d           = v_q;
      mode_d        = mode_q;
      next_addr_d   = next_addr_q;
      vaddr_d       = vaddr_q;
      frame_count_d = frame_count_q;
      start_frame   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               start_frame = 1'b1;
            end
         end
         ST_LEAD: begin
            if (cnt_q == LEAD_LAST) begin
               state_d = ST_LINE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_LINE: begin
            if (cnt_q == H_LAST) begin
               cnt_d = '0;
               if (v_q == V_LAST) begin
                  state_d       = ST_VBLANK;
                  frame_count_d = frame_count_q + 10'd1;
               end else begin
                  state_d = ST_HBLANK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HBLANK: begin
            if (cnt_q == HB_LAST) begin
               state_d = ST_LINE;
               cnt_d   = '0;
               v_d     = v_q + VW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_VBLANK: begin
            if (cnt_q == VB_LAST) begin
               cnt_d = '0;
               if (enable) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Mode is only captured here, so mid-frame changes wait for the next frame.
      if (start_frame) begin
         state_d     = ST_LEAD;
         cnt_d       = '0;
         v_d         = '0;
         mode_d      = mode;
         next_addr_d = '0;
         vaddr_d     = '0;
      end

      in_line = (state_d == ST_LINE);
      fv_d    = (state_d == ST_LEAD) || in_line || (state_d == ST_HBLANK);
      lv_d    = in_line;
      dv_d    = in_line;

      if (in_line) begin
         vaddr_d     = next_addr_q;
         next_addr_d = next_addr_q + 20'd1;
      end

      h8         = 8'(cnt_d);
      v8         = 8'(v_d);
      data_out_d = 8'd0;
      if (in_line) begin
         case (mode_d)
            2'd1:    data_out_d = (h8[4] ^ v8[4]) ? 8'd255 : 8'd0;
            2'd2:    data_out_d = 8'd128;
            2'd3:    data_out_d = h8;
            default: data_out_d = 8'd0;
         endcase
      end

      // Look one cycle ahead so the read lands exactly on its pixel cycle.
      next_is_line = ((state_d == ST_LEAD)   && (cnt_d == LEAD_LAST)) ||
                     ((state_d == ST_LINE)   && (cnt_d != H_LAST))    ||
                     ((state_d == ST_HBLANK) && (cnt_d == HB_LAST));
      mem_rd_d   = (mode_d == 2'd0) && next_is_line;
      mem_addr_d = mem_rd_d ? next_addr_d : mem_addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         v_q           <= '0;
         mode_q        <= 2'd0;
         next_addr_q   <= '0;
         vaddr_q       <= '0;
         frame_count_q <= '0;
         fv_q          <= 1'b0;
         lv_q          <= 1'b0;
         dv_q          <= 1'b0;
         data_out_q    <= 8'd0;
         mem_rd_q      <= 1'b0;
         mem_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         v_q           <= v_d;
         mode_q        <= mode_d;
         next_addr_q   <= next_addr_d;
         vaddr_q       <= vaddr_d;
         frame_count_q <= frame_count_d;
         fv_q          <= fv_d;
         lv_q          <= lv_d;
         dv_q          <= dv_d;
         data_out_q    <= data_out_d;
         mem_rd_q      <= mem_rd_d;
         mem_addr_q    <= mem_addr_d;
      end
   end

   // Memory pixels arrive from the memory's own output register on the pixel cycle.
   assign vid.video_data_out    = ((mode_q == 2'd0) && dv_q) ? vid.mem_data : data_out_q;
   assign vid.video_frame_valid = fv_q;
   assign vid.video_line_valid  = lv_q;
   assign vid.video_data_valid  = dv_q;
   assign vid.video_address     = vaddr_q;
   assign vid.mem_rd            = mem_rd_q;
   assign vid.mem_addr          = mem_addr_q;
   assign frame_count           = frame_count_q;
   assign busy                  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_maze_video_source.sv
// ============================================================================
// Module   : tb_maze_video_source
// Brief    : Directed self-checking bench for maze_video_source.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_maze_video_source;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, enable;
   logic [1:0] mode;
   logic [9:0] frame_count;
   logic       busy;
   logic       reset_b, enable_b;
   logic [1:0] mode_b;
   logic [9:0] frame_count_b;
   logic       busy_b;

   maze_video_source_if a_if();
   maze_video_source_if b_if();

   maze_video_source #(
      .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(2), .V_BLANK(5), .FV_LEAD(3)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .frame_count(frame_count), .busy(busy), .vid(a_if)
   );

   maze_video_source dut_b (
      .clk(clk), .reset(reset_b), .enable(enable_b), .mode(mode_b),
      .frame_count(frame_count_b), .busy(busy_b), .vid(b_if)
   );

   // Frame memory model: returns addr[7:0] one cycle after the read strobe.
   always @(posedge clk) begin
      if (reset) a_if.mem_data <= 8'd0;
      else if (a_if.mem_rd) a_if.mem_data <= a_if.mem_addr[7:0];
   end
   assign b_if.mem_data = 8'd0;

   int tests = 0;
   int fails = 0;

   int          fv_len, lead_len, n_pix, n_rd;
   logic [9:0]  fc_before, fc_at_fall;
   logic [7:0]  pix    [64];
   logic [19:0] paddr  [64];
   logic        prd    [64];
   logic [19:0] pmaddr [64];
   int          drop_at   = -1;
   int          switch_at = -1;

   task automatic apply_reset();
      @(negedge clk);
      reset  = 1'b1;
      enable = 1'b0;
      mode   = 2'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Records one frame of instance A, from frame_valid rise to its fall.
   task automatic run_frame();
      int          k;
      logic        prev_rd;
      logic [19:0] prev_maddr;
      fv_len = 0; lead_len = -1; n_pix = 0; n_rd = 0;
      prev_rd = 1'b0; prev_maddr = '0;
      k = 0;
      while (a_if.video_frame_valid !== 1'b1 && k < 200) begin
         prev_rd = a_if.mem_rd; prev_maddr = a_if.mem_addr;
         @(negedge clk); k++;
      end
      if (k >= 200) begin
         tests++; fails++;
         $display("FAIL frame_start: frame_valid=%b, required 1 within 200 cycles",
                  a_if.video_frame_valid);
         return;
      end
      fc_before = frame_count;
      while (a_if.video_frame_valid === 1'b1 && fv_len < 500) begin
         fc_before = frame_count;
         if (a_if.video_line_valid === 1'b1 && lead_len < 0) lead_len = fv_len;
         if (a_if.mem_rd === 1'b1) n_rd++;
         if (a_if.video_data_valid === 1'b1 && n_pix < 64) begin
            pix[n_pix]    = a_if.video_data_out;
            paddr[n_pix]  = a_if.video_address;
            prd[n_pix]    = prev_rd;
            pmaddr[n_pix] = prev_maddr;
            if (n_pix == drop_at)   enable = 1'b0;
            if (n_pix == switch_at) mode   = 2'd3;
            n_pix++;
         end
         prev_rd = a_if.mem_rd; prev_maddr = a_if.mem_addr;
         fv_len++;
         @(negedge clk);
      end
      fc_at_fall = frame_count;
      if (fv_len >= 500) begin
         tests++; fails++;
         $display("FAIL frame_end: frame_valid still high after %0d cycles, required fall", fv_len);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; enable = 1'b1; mode = 2'd2;
      repeat (3) @(negedge clk);
      tests++; if (a_if.video_frame_valid !== 1'b0) begin fails++; $display("FAIL rst_fv: got %b, required 0", a_if.video_frame_valid); end
      tests++; if (a_if.video_line_valid !== 1'b0) begin fails++; $display("FAIL rst_lv: got %b, required 0", a_if.video_line_valid); end
      tests++; if (a_if.video_data_valid !== 1'b0) begin fails++; $display("FAIL rst_dv: got %b, required 0", a_if.video_data_valid); end
      tests++; if (a_if.video_data_out !== 8'd0) begin fails++; $display("FAIL rst_data: got %0d, required 0", a_if.video_data_out); end
      tests++; if (a_if.video_address !== 20'd0) begin fails++; $display("FAIL rst_addr: got %0d, required 0", a_if.video_address); end
      tests++; if (a_if.mem_rd !== 1'b0) begin fails++; $display("FAIL rst_mem_rd: got %b, required 0", a_if.mem_rd); end
      tests++; if (a_if.mem_addr !== 20'd0) begin fails++; $display("FAIL rst_mem_addr: got %0d, required 0", a_if.mem_addr); end
      tests++; if (frame_count !== 10'd0) begin fails++; $display("FAIL rst_fc: got %0d, required 0", frame_count); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
      reset = 1'b0; enable = 1'b0;
   endtask

   task automatic test_frame_mode2();
      int bad, lo;
      apply_reset();
      mode = 2'd2; enable = 1'b1;
      @(negedge clk);
      tests++; if ({a_if.video_frame_valid, busy} !== 2'b11) begin fails++; $display("FAIL start_edge: fv,busy=%b, required 11", {a_if.video_frame_valid, busy}); end
      run_frame();
      tests++; if (fv_len != 41) begin fails++; $display("FAIL fv_len: got %0d, required 41", fv_len); end
      tests++; if (lead_len != 3) begin fails++; $display("FAIL lead_len: got %0d, required 3", lead_len); end
      tests++; if (n_pix != 32) begin fails++; $display("FAIL m2_pixels: got %0d, required 32", n_pix); end
      bad = -1;
      for (int i = 0; i < 32; i++) if (pix[i] !== 8'd128 && bad < 0) bad = i;
      tests++; if (bad >= 0) begin fails++; $display("FAIL m2_value: pixel %0d got %0d, required 128", bad, pix[bad]); end
      bad = -1;
      for (int i = 0; i < 32; i++) if (paddr[i] !== 20'(i) && bad < 0) bad = i;
      tests++; if (bad >= 0) begin fails++; $display("FAIL m2_addr: pixel %0d got %0d, required %0d", bad, paddr[bad], bad); end
      tests++; if (n_rd != 0) begin fails++; $display("FAIL m2_mem_rd: got %0d reads, required 0", n_rd); end
      tests++; if (fc_before !== 10'd0 || fc_at_fall !== 10'd1) begin fails++; $display("FAIL fc_step: got %0d->%0d, required 0->1", fc_before, fc_at_fall); end
      lo = 0;
      while (a_if.video_frame_valid !== 1'b1 && lo < 20) begin lo++; @(negedge clk); end
      tests++; if (lo != 5) begin fails++; $display("FAIL vblank_len: got %0d, required 5", lo); end
      enable = 1'b0;
   endtask

   task automatic test_mode0();
      int bad_p, bad_a, bad_r;
      apply_reset();
      mode = 2'd0; enable = 1'b1;
      run_frame();
      tests++; if (n_pix != 32) begin fails++; $display("FAIL m0_pixels: got %0d, required 32", n_pix); end
      bad_p = -1; bad_a = -1; bad_r = -1;
      for (int i = 0; i < 32; i++) begin
         if (pix[i] !== 8'(i) && bad_p < 0) bad_p = i;
         if (paddr[i] !== 20'(i) && bad_a < 0) bad_a = i;
         if ((prd[i] !== 1'b1 || pmaddr[i] !== 20'(i)) && bad_r < 0) bad_r = i;
      end
      tests++; if (bad_p >= 0) begin fails++; $display("FAIL m0_data: pixel %0d got %0d, required %0d", bad_p, pix[bad_p], bad_p); end
      tests++; if (bad_a >= 0) begin fails++; $display("FAIL m0_addr: pixel %0d got %0d, required %0d", bad_a, paddr[bad_a], bad_a); end
      tests++; if (bad_r >= 0) begin fails++; $display("FAIL m0_rd_lead: pixel %0d prior rd=%b addr=%0d, required 1 and %0d", bad_r, prd[bad_r], pmaddr[bad_r], bad_r); end
      tests++; if (n_rd != 32) begin fails++; $display("FAIL m0_rd_count: got %0d, required 32", n_rd); end
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      apply_reset();
      mode = 2'd2; enable = 1'b1; drop_at = 19;
      run_frame();
      drop_at = -1;
      tests++; if (n_pix != 32 || fv_len != 41) begin fails++; $display("FAIL drop_full_frame: got %0d pixels %0d cycles, required 32 and 41", n_pix, fv_len); end
      repeat (8) @(negedge clk);
      tests++; if (busy !== 1'b0 || a_if.video_frame_valid !== 1'b0) begin fails++; $display("FAIL drop_idle: busy,fv=%b%b, required 00", busy, a_if.video_frame_valid); end
      tests++; if (frame_count !== 10'd1) begin fails++; $display("FAIL drop_fc: got %0d, required 1", frame_count); end
   endtask

   task automatic test_reset_midframe();
      int k;
      apply_reset();
      mode = 2'd3; enable = 1'b1;
      k = 0;
      while (!(a_if.video_data_valid === 1'b1 && a_if.video_address === 20'd13) && k < 200) begin @(negedge clk); k++; end
      tests++; if (k >= 200) begin fails++; $display("FAIL mid_reach: pixel 13 not seen, addr=%0d, required 13", a_if.video_address); end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({a_if.video_frame_valid, a_if.video_line_valid, a_if.video_data_valid, a_if.video_data_out,
           a_if.video_address, a_if.mem_rd, a_if.mem_addr, frame_count, busy} !== '0) begin
         fails++;
         $display("FAIL mid_reset: fv=%b lv=%b dv=%b data=%0d addr=%0d rd=%b maddr=%0d fc=%0d busy=%b, required all 0",
                  a_if.video_frame_valid, a_if.video_line_valid, a_if.video_data_valid, a_if.video_data_out,
                  a_if.video_address, a_if.mem_rd, a_if.mem_addr, frame_count, busy);
      end
      reset = 1'b0;
      run_frame();
      tests++; if (n_pix != 32) begin fails++; $display("FAIL mid_next_count: got %0d, required 32", n_pix); end
      tests++; if (paddr[0] !== 20'd0 || pix[0] !== 8'd0) begin fails++; $display("FAIL mid_first_pixel: addr=%0d data=%0d, required 0 and 0", paddr[0], pix[0]); end
      tests++; if (pix[13] !== 8'd5) begin fails++; $display("FAIL mid_ramp: pixel 13 got %0d, required 5", pix[13]); end
      enable = 1'b0;
   endtask

   task automatic test_mode_switch();
      int bad;
      apply_reset();
      mode = 2'd2; enable = 1'b1; switch_at = 10;
      run_frame();
      switch_at = -1;
      bad = -1;
      for (int i = 0; i < 32; i++) if (pix[i] !== 8'd128 && bad < 0) bad = i;
      tests++; if (n_pix != 32 || bad >= 0) begin fails++; $display("FAIL switch_current: %0d pixels, first bad %0d, required 32 pixels all 128", n_pix, bad); end
      run_frame();
      bad = -1;
      for (int i = 0; i < 32; i++) if (pix[i] !== 8'(i % 8) && bad < 0) bad = i;
      tests++; if (n_pix != 32 || bad >= 0) begin fails++; $display("FAIL switch_next: %0d pixels, first bad %0d, required 32 pixels ramp 0..7", n_pix, bad); end
      enable = 1'b0;
   endtask

   task automatic test_grid();
      logic [7:0] line0 [32];
      logic [7:0] l16;
      bit         found, rd_seen;
      int         bad;
      for (int i = 0; i < 32; i++) line0[i] = 8'hxx;
      l16 = 8'hxx; found = 0; rd_seen = 0;
      @(negedge clk);
      reset_b = 1'b1; enable_b = 1'b0; mode_b = 2'd1;
      repeat (2) @(negedge clk);
      reset_b = 1'b0; enable_b = 1'b1;
      for (int k = 0; k < 20000 && !found; k++) begin
         @(negedge clk);
         if (b_if.mem_rd === 1'b1) rd_seen = 1;
         if (b_if.video_data_valid === 1'b1) begin
            if (b_if.video_address < 20'd32) line0[b_if.video_address[4:0]] = b_if.video_data_out;
            if (b_if.video_address == 20'd11232) begin l16 = b_if.video_data_out; found = 1; end
         end
      end
      tests++; if (!found) begin fails++; $display("FAIL grid_reach: line 16 pixel 0 not seen, required within 20000 cycles"); end
      bad = -1;
      for (int i = 0; i < 16; i++) if (line0[i] !== 8'd0 && bad < 0) bad = i;
      tests++; if (bad >= 0) begin fails++; $display("FAIL grid_low: line0 pixel %0d got %0d, required 0", bad, line0[bad]); end
      bad = -1;
      for (int i = 16; i < 32; i++) if (line0[i] !== 8'd255 && bad < 0) bad = i;
      tests++; if (bad >= 0) begin fails++; $display("FAIL grid_high: line0 pixel %0d got %0d, required 255", bad, line0[bad]); end
      tests++; if (l16 !== 8'd255) begin fails++; $display("FAIL grid_line16: got %0d, required 255", l16); end
      tests++; if (rd_seen) begin fails++; $display("FAIL grid_mem_rd: got read strobe, required none in mode 1"); end
      enable_b = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; mode = 2'd0;
      reset_b = 1'b1; enable_b = 1'b0; mode_b = 2'd0;
      test_reset();
      test_frame_mode2();
      test_mode0();
      test_enable_drop();
      test_reset_midframe();
      test_mode_switch();
      test_grid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/maze_video_source.md
MAZE_VIDEO_SOURCE -- requirements
Module: maze_video_source

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 702, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 288, meaning active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 16, meaning line_valid-low cycles between lines.
REQ-004 The block SHALL have parameter V_BLANK, default 64, meaning frame_valid-low cycles between frames.
REQ-005 The block SHALL have parameter FV_LEAD, default 4, meaning cycles from frame_valid rise to first line_valid rise.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port enable, input, 1 bit: level; frames are generated while high.
REQ-009 The block SHALL have port mode, input, 2 bits: pixel source select, sampled at frame start.
REQ-010 The block SHALL have port mem_rd, output, 1 bit: frame-memory read strobe.
REQ-011 The block SHALL have port mem_addr, output, 20 bits: frame-memory read address.
REQ-012 The block SHALL have port mem_data, input, 8 bits: read data, valid exactly 1 cycle after mem_rd.
REQ-013 The block SHALL have port video_frame_valid, output, 1 bit: high for the whole frame.
REQ-014 The block SHALL have port video_line_valid, output, 1 bit: high for each active line.
REQ-015 The block SHALL have port video_data_valid, output, 1 bit: high on each active pixel.
REQ-016 The block SHALL have port video_data_out, output, 8 bits: pixel value.
REQ-017 The block SHALL have port video_address, output, 20 bits: linear index v*H_ACTIVE+h of the current pixel.
REQ-018 The block SHALL have port frame_count, output, 10 bits: completed frames, wrapping 1023->0.
REQ-019 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, LEAD, LINE, HBLANK and VBLANK.
REQ-021 IDLE->LEAD SHALL occur when enable=1; in IDLE, mode SHALL be latched and video_frame_valid SHALL be set to 1 on that same edge.
REQ-022 LEAD SHALL last FV_LEAD cycles with frame_valid=1 and line_valid=0, then go to LINE.
REQ-023 LINE SHALL last exactly H_ACTIVE cycles, with line_valid=data_valid=1 on every cycle, and h running 0..H_ACTIVE-1.
REQ-024 After LINE, the FSM SHALL go to HBLANK if v<V_ACTIVE-1, else to VBLANK.
REQ-025 HBLANK SHALL last H_BLANK cycles with frame_valid=1 and line_valid=0, then increment v and go to LINE.
REQ-026 VBLANK SHALL last V_BLANK cycles with all three valids=0.
REQ-027 frame_count SHALL increment on VBLANK entry.
REQ-028 At the end of VBLANK, the FSM SHALL go to LEAD (relatching mode) if enable=1, else to IDLE.
REQ-029 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame SHALL complete in full.
REQ-030 Mode 0 SHALL output pixel = mem_data.
REQ-031 In mode 0, mem_rd SHALL be issued one cycle before each active pixel, with mem_addr = address of that pixel.
REQ-032 In modes 1-3, mem_rd SHALL be 0.
REQ-033 Mode 1 SHALL output pixel = 8'd255 if h[4]^v[4], else 8'd0 (synthetic grid).
REQ-034 Mode 2 SHALL output pixel = constant 8'd128.
REQ-035 Mode 3 SHALL output pixel = h[7:0] (ramp).
REQ-036 video_data_out and video_address SHALL be registered and aligned with data_valid.
REQ-037 Outside active pixels, video_data_out SHALL be 0.
REQ-038 Outside active pixels, video_address SHALL hold its last value.
REQ-039 The address SHALL be kept as an incrementing 20-bit counter, not a multiplier, and SHALL be cleared at LEAD entry.
REQ-040 Changes of mode mid-frame SHALL be ignored.

Reset
REQ-041 reset=1 SHALL, on the next edge, force IDLE, all three valids=0, data_out=0, address=0, mem_rd=0, mem_addr=0, frame_count=0 and busy=0, regardless of state.
REQ-042 Reset SHALL take priority over enable.
REQ-043 After a mid-frame reset, no partial-frame continuation SHALL occur; the next frame SHALL start with h=v=0.

Verification
REQ-044 With H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=5, FV_LEAD=3 and enable held high in mode 2: frame_valid SHALL be high for 3+4*8+3*2=41 cycles then low for 5 cycles, with 32 data_valid pulses, all pixels 128, and frame_count incrementing 0->1 at frame_valid fall.
REQ-045 In mode 0 with a memory model returning addr[7:0]: pixels SHALL be 0..31 in order, video_address SHALL equal the pixel value, and each mem_rd SHALL precede its pixel by exactly 1 cycle.
REQ-046 In mode 1 with defaults: line 0 pixels 0-15 SHALL be 0, pixels 16-31 SHALL be 255, and line 16 pixel 0 SHALL be 255.
REQ-047 With enable dropped at line 2, pixel 3 of frame 0: the frame SHALL still deliver all 32 pixels, then go to IDLE with busy=0 and frame_count=1.
REQ-048 With reset asserted at line 1, pixel 5: the next cycle SHALL show all outputs 0 and IDLE, and the next frame's first pixel SHALL have address 0.
REQ-049 With mode switched 2->3 mid-frame: the current frame SHALL remain all 128, and the next frame SHALL ramp 0..7 on each line.
